nco_freq_ctrl: RTL
==================

// Module: nco_freq_ctrl
// PURPOSE
// - Sits between uart_rx and sinewave_generator. Parses ASCII command bytes into a target tone frequency in Hz.
// - Converts Hz to an NCO phase increment with a sequential shift-add multiplier.
// - Glides the live phase_increment toward that target, one step per sample strobe.
// - Replaces the ad-hoc byte decode in the top level. Adds decimal entry, clamping and click-free frequency changes.
// PARAMETERS
// - PHASE_WIDTH  64                   NCO phase increment width
// - HZ_WIDTH     20                   width of the Hz register and digit accumulator
// - HZ_INC       64'd196765270119569  phase increment per 1 Hz (2^64 / 93750 Hz sample rate)
// - MAX_HZ       40000                upper clamp for the target frequency, in Hz
// - GLIDE_STEP   64'd0                per-strobe increment change; 0 = load target immediately
// PORTS
// - clk              in   1            system clock (PLL clk0, 48 MHz)
// - arst             in   1            asynchronous reset, active high
// - rx_dv            in   1            one-cycle strobe: rx_byte valid
// - rx_byte          in   8            received ASCII byte
// - sample_ce        in   1            one-cycle sample strobe (DAC clk_strobe, synchronised to clk)
// - phase_increment  out  PHASE_WIDTH  live increment driven to the NCO
// - freq_hz          out  HZ_WIDTH     committed target frequency, in Hz
// - busy             out  1            high while MULT runs or while a glide is in progress
// - cmd_err          out  1            one-cycle pulse on a rejected byte
// BEHAVIOUR
// - Reset: phase_increment=0, freq_hz=0, target=0, acc=0, digit_cnt=0, busy=0, cmd_err=0, state=IDLE.
// - Reset is asynchronous and aborts any MULT or glide in progress.
// - States: IDLE, DIGITS, MULT. Glide runs independently of the state, from the target register.
// - IDLE, on rx_dv:
//   - '0'-'9' -> acc=d, digit_cnt=1, go DIGITS.
//   - Presets: 'a'/'b'/'f'/'g' -> freq_hz=1000/5000/10000/15000.
//   - Steps: 'm'/'n' -> freq_hz +/-1000; 'p'/'o' -> freq_hz +/-100.
//   - 'z' -> freq_hz=0.
//   - Every preset/step/'z' command then goes to MULT.
//   - Any other byte -> cmd_err pulse; freq_hz unchanged.
// - DIGITS, on rx_dv:
//   - Digit -> acc=acc*10+d, saturating at MAX_HZ.
//   - CR (0x0D) -> freq_hz=acc, go MULT.
//   - ESC (0x1B) -> discard acc, go IDLE.
//   - Other byte -> cmd_err pulse, discard acc, go IDLE.
// - Clamping of step results:
//   - Subtracting below 0 yields 0.
//   - Adding above MAX_HZ yields MAX_HZ.
//   - There is never a wrap-around.
// - MULT:
//   - HZ_WIDTH-cycle shift-add of freq_hz * HZ_INC. The product is truncated to PHASE_WIDTH.
//   - target is updated in the cycle after the last iteration, then the FSM returns to IDLE.
//   - Latency from rx_dv to target update: HZ_WIDTH+2 cycles (22).
//   - A byte arriving during MULT is dropped and pulses cmd_err.
// - Glide, evaluated only on sample_ce:
//   - GLIDE_STEP=0 -> phase_increment=target.
//   - |target-phase_increment| <= GLIDE_STEP -> snap to target.
//   - Otherwise phase_increment moves by GLIDE_STEP toward target.
//   - The difference is computed unsigned, as a magnitude; the output never overshoots.
//   - A new target arriving mid-glide redirects the glide from the current value.
// - busy = (state==MULT) | (phase_increment != target).
// - rx_dv and sample_ce in the same cycle are both serviced.
// TESTING
// - Reset, then rx 'a': after 22 cycles target = 1000*HZ_INC = 196765270119569000.
//   - On the next sample_ce, phase_increment equals target; freq_hz=1000.
// - Digit entry: rx "440\r" -> freq_hz=440, phase_increment=440*HZ_INC.
//   - Repeat with rx "4" then ESC: freq_hz stays 440 and no MULT runs.
// - Clamping: at freq_hz=500, rx 'n' -> freq_hz=0, phase_increment=0.
//   - Digits "99999\r" -> freq_hz=40000; then 'p' -> freq_hz stays 40000.
// - Glide: GLIDE_STEP=HZ_INC*10, 0 -> 'a' -> 100 sample_ce strobes to reach target.
//   - Check monotonic rise, busy high throughout and low after the snap.
//   - Change to 'z' mid-way and check a monotonic fall to 0.
// - Errors: rx 'x' in IDLE -> one-cycle cmd_err, no state change.
//   - A byte injected during MULT -> cmd_err, and the first command's result stands.
// - Reset mid-MULT (assert arst at cycle 10 of MULT): all outputs 0 immediately, FSM in IDLE.
//   - A subsequent 'b' gives freq_hz=5000.

Source files
------------

// File: rtl/nco_freq_ctrl.sv
// nco_freq_ctrl
// Turns ASCII command bytes from the UART into a target tone frequency in Hz.
// The frequency is converted to an NCO phase increment by a sequential
// shift-add multiplier. The live increment then glides toward that target,
// one step per sample strobe.
//
// Ports
//   clk              system clock
//   arst             asynchronous reset, active high
//   rx_dv            one-cycle strobe, rx_byte valid
//   rx_byte          received ASCII byte
//   sample_ce        one-cycle sample strobe, already synchronised to clk
//   phase_increment  live increment driven to the NCO
//   freq_hz          committed target frequency in Hz
//   busy             multiplier running or glide not yet settled
//   cmd_err          one-cycle pulse on a rejected byte
//
// state  | meaning
// IDLE   | waiting for a command byte
// DIGITS | collecting decimal digits; CR commits, ESC abandons
// MULT   | shift-add freq_hz * HZ_INC in progress; input bytes rejected
module nco_freq_ctrl #(
  parameter int                     PHASE_WIDTH = 64,
  parameter int                     HZ_WIDTH    = 20,
  parameter logic [PHASE_WIDTH-1:0] HZ_INC      = 64'd196765270119569,
  parameter int                     MAX_HZ      = 40000,
  parameter logic [PHASE_WIDTH-1:0] GLIDE_STEP  = 64'd0
) (
  input  logic                   clk,
  input  logic                   arst,
  input  logic                   rx_dv,
  input  logic [7:0]             rx_byte,
  input  logic                   sample_ce,
  output logic [PHASE_WIDTH-1:0] phase_increment,
  output logic [HZ_WIDTH-1:0]    freq_hz,
  output logic                   busy,
  output logic                   cmd_err
);

  typedef enum logic [1:0] {IDLE, DIGITS, MULT} state_t;

  // The multiplier sequence is one load cycle, HZ_WIDTH add/shift cycles
  // and one cycle that writes the product to target.
  localparam int CNT_W = $clog2(HZ_WIDTH + 2);
  localparam logic [CNT_W-1:0] CNT_ITER_LAST = CNT_W'(HZ_WIDTH);
  localparam logic [CNT_W-1:0] CNT_LAST      = CNT_W'(HZ_WIDTH + 1);

  localparam logic [HZ_WIDTH-1:0]   MAX_V  = HZ_WIDTH'(MAX_HZ);
  localparam logic [HZ_WIDTH+3:0]   MAX_W  = (HZ_WIDTH + 4)'(MAX_HZ);
  localparam logic [7:0]            CH_CR  = 8'h0D;
  localparam logic [7:0]            CH_ESC = 8'h1B;

  state_t                   state, state_nxt;
  logic [HZ_WIDTH-1:0]      acc, acc_nxt;
  logic [2:0]               digit_cnt, digit_cnt_nxt;
  logic [HZ_WIDTH-1:0]      freq_nxt;
  logic                     err_nxt;
  logic                     go_mult;

  logic [CNT_W-1:0]         mult_cnt;
  logic [HZ_WIDTH-1:0]      mplier;
  logic [PHASE_WIDTH-1:0]   mcand;
  logic [PHASE_WIDTH-1:0]   prod;
  logic [PHASE_WIDTH-1:0]   target;

  logic                     is_digit;
  logic [3:0]               digit;
  logic [HZ_WIDTH+3:0]      acc_wide;
  logic [HZ_WIDTH+3:0]      acc_x10;
  logic [HZ_WIDTH-1:0]      acc_sat;

  logic [PHASE_WIDTH-1:0]   diff;
  logic                     rising;

  function automatic logic [HZ_WIDTH-1:0] sat_add(input logic [HZ_WIDTH-1:0] f,
                                                  input logic [HZ_WIDTH-1:0] d);
    logic [HZ_WIDTH:0] s;
    s = {1'b0, f} + {1'b0, d};
    if (s > {1'b0, MAX_V}) return MAX_V;
    return s[HZ_WIDTH-1:0];
  endfunction

  function automatic logic [HZ_WIDTH-1:0] sat_sub(input logic [HZ_WIDTH-1:0] f,
                                                  input logic [HZ_WIDTH-1:0] d);
    if (f < d) return '0;
    return f - d;
  endfunction

  assign is_digit = (rx_byte >= "0") && (rx_byte <= "9");
  assign digit    = rx_byte[3:0];

  // acc <= MAX_HZ, so acc*10+9 fits in four extra bits before the clamp
  assign acc_wide = {4'b0000, acc};
  assign acc_x10  = (acc_wide << 3) + (acc_wide << 1) + {{HZ_WIDTH{1'b0}}, digit};
  assign acc_sat  = (acc_x10 > MAX_W) ? MAX_V : acc_x10[HZ_WIDTH-1:0];

  always_comb begin
    state_nxt     = state;
    acc_nxt       = acc;
    digit_cnt_nxt = digit_cnt;
    freq_nxt      = freq_hz;
    err_nxt       = 1'b0;
    go_mult       = 1'b0;
    case (state)
      IDLE: begin
        if (rx_dv) begin
          if (is_digit) begin
            acc_nxt       = HZ_WIDTH'(digit);
            digit_cnt_nxt = 3'd1;
            state_nxt     = DIGITS;
          end else begin
            go_mult = 1'b1;
            case (rx_byte)
              "a":     freq_nxt = HZ_WIDTH'(1000);
              "b":     freq_nxt = HZ_WIDTH'(5000);
              "f":     freq_nxt = HZ_WIDTH'(10000);
              "g":     freq_nxt = HZ_WIDTH'(15000);
              "m":     freq_nxt = sat_add(freq_hz, HZ_WIDTH'(1000));
              "n":     freq_nxt = sat_sub(freq_hz, HZ_WIDTH'(1000));
              "p":     freq_nxt = sat_add(freq_hz, HZ_WIDTH'(100));
              "o":     freq_nxt = sat_sub(freq_hz, HZ_WIDTH'(100));
              "z":     freq_nxt = '0;
              default: begin
                go_mult = 1'b0;
                err_nxt = 1'b1;
              end
            endcase
          end
        end
      end
      DIGITS: begin
        if (rx_dv) begin
          if (is_digit) begin
            acc_nxt = acc_sat;
            if (digit_cnt != 3'd7) digit_cnt_nxt = digit_cnt + 3'd1;
          end else begin
            acc_nxt       = '0;
            digit_cnt_nxt = '0;
            state_nxt     = IDLE;
            if (rx_byte == CH_CR) begin
              freq_nxt = acc;
              go_mult  = 1'b1;
            end else if (rx_byte != CH_ESC) begin
              err_nxt = 1'b1;
            end
          end
        end
      end
      MULT: begin
        if (rx_dv) err_nxt = 1'b1;
        if (mult_cnt == CNT_LAST) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
    if (go_mult) state_nxt = MULT;
  end

  always_ff @(posedge clk or posedge arst) begin
    if (arst) begin
      state     <= IDLE;
      acc       <= '0;
      digit_cnt <= '0;
      freq_hz   <= '0;
      cmd_err   <= 1'b0;
    end else begin
      state     <= state_nxt;
      acc       <= acc_nxt;
      digit_cnt <= digit_cnt_nxt;
      freq_hz   <= freq_nxt;
      cmd_err   <= err_nxt;
    end
  end

  // Shift-add multiplier: freq_hz is latched in the load cycle, so the
  // committed frequency cannot change under the running product.
  always_ff @(posedge clk or posedge arst) begin
    if (arst) begin
      mult_cnt <= '0;
      mplier   <= '0;
      mcand    <= '0;
      prod     <= '0;
      target   <= '0;
    end else if (go_mult) begin
      mult_cnt <= '0;
    end else if (state == MULT) begin
      mult_cnt <= mult_cnt + 1'b1;
      if (mult_cnt == '0) begin
        mplier <= freq_hz;
        mcand  <= HZ_INC;
        prod   <= '0;
      end else if (mult_cnt <= CNT_ITER_LAST) begin
        if (mplier[0]) prod <= prod + mcand;
        mcand  <= mcand << 1;
        mplier <= mplier >> 1;
      end else begin
        target <= prod;
      end
    end
  end

  // Magnitude of the remaining distance; snapping when it is within one
  // step keeps the output from overshooting.
  assign rising = target > phase_increment;
  assign diff   = rising ? (target - phase_increment) : (phase_increment - target);

  always_ff @(posedge clk or posedge arst) begin
    if (arst) begin
      phase_increment <= '0;
    end else if (sample_ce) begin
      if ((GLIDE_STEP == '0) || (diff <= GLIDE_STEP)) begin
        phase_increment <= target;
      end else if (rising) begin
        phase_increment <= phase_increment + GLIDE_STEP;
      end else begin
        phase_increment <= phase_increment - GLIDE_STEP;
      end
    end
  end

  assign busy = (state == MULT) || (phase_increment != target);

endmodule
